// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave: two RW operands (OPA/OPB), RO sum and RO OKAY-write count at BASE_ADDR+0x0..0xC.
// Latency: B one cycle after the later of AW/W is accepted; R valid on the edge AR is accepted.
// Backpressure: one write and one read in flight; readies stay low until the matching B/R handshake.
module axi_lite_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
    localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [DATA_WIDTH-1:0] opa, opb, wcnt, sum;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]         wstrb_q;
    logic                  aw_done, w_done;
    logic                  aw_hs, w_hs;
    logic                  unused_wstrb_msb;

    assign sum              = opa + opb;
    assign aw_hs            = s_axi_awvalid && s_axi_awready;
    assign w_hs             = s_axi_wvalid && s_axi_wready;
    assign unused_wstrb_msb = s_axi_wstrb[NB];

    // Base is 16-byte aligned, so the upper bits select the window and [1:0] must be zero.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        return (a[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]) && (a[1:0] == 2'b00);
    endfunction

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            opa           <= '0;
            opb           <= '0;
            wcnt          <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q      <= s_axi_awaddr;
                        aw_done       <= 1'b1;
                        s_axi_awready <= 1'b0;
                    end else if (!aw_done) begin
                        s_axi_awready <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q      <= s_axi_wdata;
                        wstrb_q      <= s_axi_wstrb[NB-1:0];
                        w_done       <= 1'b1;
                        s_axi_wready <= 1'b0;
                    end else if (!w_done) begin
                        s_axi_wready <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs))
                        w_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    s_axi_bvalid <= 1'b1;
                    w_state      <= W_RESP;
                    if (!addr_hit(awaddr_q)) begin
                        s_axi_bresp <= RESP_DECERR;
                    end else if (awaddr_q[3]) begin
                        s_axi_bresp <= RESP_SLVERR;
                    end else begin
                        s_axi_bresp <= RESP_OKAY;
                        wcnt        <= wcnt + DATA_WIDTH'(1);
                        for (int i = 0; i < NB; i++) begin
                            if (wstrb_q[i]) begin
                                if (awaddr_q[2]) opb[8*i +: 8] <= wdata_q[8*i +: 8];
                                else             opa[8*i +: 8] <= wdata_q[8*i +: 8];
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read data is captured from the current register values, so a read on a commit edge sees pre-write state.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        r_state       <= R_DATA;
                        if (addr_hit(s_axi_araddr)) begin
                            s_axi_rresp <= RESP_OKAY;
                            case (s_axi_araddr[3:2])
                                2'd0:    s_axi_rdata <= opa;
                                2'd1:    s_axi_rdata <= opb;
                                2'd2:    s_axi_rdata <= sum;
                                default: s_axi_rdata <= wcnt;
                            endcase
                        end else begin
                            s_axi_rresp <= RESP_DECERR;
                            s_axi_rdata <= '0;
                        end
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI4-Lite register slave that terminates one master port of the two-way bus interconnect (the `m1_axi_*` side), decoding the 0x0/0x4/0x8/0xC window. It holds two read/write operand registers, a read-only sum and a read-only count of completed writes. AW and W are accepted independently, each write gets a B response, and each read gets one R beat with a decoded response code.

## Interface
- `DATA_WIDTH`, 32: data bus width in bits; a multiple of 8.
- `ADDR_WIDTH`, 8: address bus width in bits.
- `RESP_WIDTH`, 3: response field width; codes are zero-extended.
- `BASE_ADDR`, 0: byte address of register 0; must be 16-byte aligned.

Ports:
- `s_axi_aclk`  in  1  single clock; all logic on the rising edge.
- `s_axi_areset`  in  1  reset, synchronous, active-high.
- `s_axi_awaddr`  in  ADDR_WIDTH  write address.
- `s_axi_awvalid` in 1 / `s_axi_awready` out 1: write address handshake.
- `s_axi_wdata`  in  DATA_WIDTH  write data.
- `s_axi_wstrb`  in  DATA_WIDTH/8+1  byte enables; bit i enables byte i; top bit ignored.
- `s_axi_wvalid` in 1 / `s_axi_wready` out 1: write data handshake.
- `s_axi_bresp`  out  RESP_WIDTH  write response.
- `s_axi_bvalid` out 1 / `s_axi_bready` in 1: write response handshake.
- `s_axi_araddr`  in  ADDR_WIDTH  read address.
- `s_axi_arvalid` in 1 / `s_axi_arready` out 1: read address handshake.
- `s_axi_rdata`  out  DATA_WIDTH  read data.
- `s_axi_rresp`  out  RESP_WIDTH  read response.
- `s_axi_rvalid` out 1 / `s_axi_rready` in 1: read data handshake.

## Operation
- Register map (offset from BASE_ADDR):
  - 0x0 OPA: RW.
  - 0x4 OPB: RW.
  - 0x8 SUM: RO; OPA+OPB mod 2^DATA_WIDTH.
  - 0xC WCNT: RO; count of OKAY writes, wraps to 0.
- Response codes: OKAY=0, SLVERR=2, DECERR=3.
- Address decode:
  - Exact match on BASE_ADDR+{0,4,8,C} only.
  - Any other address returns DECERR; unaligned addresses count as "any other".
- Writes:
  - A write to 0x8 or 0xC returns SLVERR and changes nothing.
  - A DECERR or SLVERR write leaves all registers unchanged.
  - An OKAY write to OPA/OPB updates only the strobed bytes and increments WCNT.
  - An all-zero strobe is still OKAY and still increments WCNT.
- Write FSM:
  - W_IDLE: awready and wready driven independently. Each drops on the edge its handshake completes and the value is latched.
  - When both address and data are latched, go to W_COMMIT.
  - W_COMMIT (one cycle): register update and WCNT increment, bvalid=1, bresp set, go to W_RESP.
  - W_RESP: hold bvalid/bresp until bvalid&bready; on that edge clear bvalid, re-raise awready and wready, return to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&arready, latch rdata/rresp from current register values, set rvalid=1, clear arready, go to R_DATA.
  - R_DATA: hold rdata/rresp/rvalid until rvalid&rready; on that edge clear rvalid, set arready=1, return to R_IDLE.
  - rdata is 0 for any error response.
- Read and write FSMs are fully independent and may overlap.

## Timing
- Reset values: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, OPA=OPB=WCNT=0.
- First edge after reset deasserts: awready, wready and arready go to 1.
- Reset asserted mid-transaction: all FSMs return to idle at that edge and outputs take reset values. The pending transaction is dropped with no response.
- Write latency:
  - Last of AW/W accepted at edge N: W_COMMIT at N+1, bvalid high from N+1.
  - Earliest next AW/W acceptance is one edge after the B handshake.
- Read latency: AR accepted at edge N, rvalid high from N with data sampled at N; at most one read outstanding.
- Read collision: a read latched on the same edge as a W_COMMIT returns pre-write values, including SUM and WCNT.
- Outputs never change while valid is high and ready is low.
- Valid signals never depend combinationally on ready.

## Test plan
- Reset, then write 0x0=0x0000_0005 and 0x4=0x0000_0007 (AW and W in the same cycle, bready=1) -> each gets bresp=0 one cycle after acceptance. Read 0x8 -> 0x0000_000C OKAY; read 0xC -> 0x0000_0002.
- Drive W two cycles before AW, wstrb=0b0010, wdata=0xAABB_CCDD to 0x0 (OPA=0x5) -> OPA=0x0000_CC05, WCNT increments.
- Write to 0x8 -> bresp=2, SUM unchanged, WCNT unchanged. Write to 0x20 -> bresp=3. Read 0x24 -> rresp=3, rdata=0.
- Hold bready=0 for 5 cycles, and separately rready=0 for 5 cycles -> bvalid/bresp and rvalid/rdata stable throughout; awready/wready/arready stay 0 until the respective handshake.
- OPA=0xFFFF_FFFF, OPB=0x2 -> SUM reads 0x0000_0001. Read 0x8 issued on the W_COMMIT edge of the OPB write -> returns the old sum.
- Assert s_axi_areset while bvalid=1 and while rvalid=1 -> both valids 0 next edge, registers 0, readies 1 one edge after reset release.
